// File: rtl/z_drain.sv
// z_drain: double-banked tile capture from a skewed array, drained row by row.
// Optional per-word b capture is enabled by defining Z_DRAIN_BIN_CAPTURE_EN.
module z_drain #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N*DW-1:0] z_in,
  input  logic [N-1:0]    clear_in,
  input  logic [N-1:0]    b_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [2:0]      out_row,
  output logic            out_last,
  output logic [N-1:0]    out_bin,
  output logic            overflow
);

  typedef enum logic [1:0] {R_IDLE, R_CAP, R_DONE} row_st_e;
  typedef enum logic {O_IDLE, O_SEND} out_st_e;

  logic [DW-1:0] mem_q [2][N][N];

  row_st_e    row_st_q [N];
  row_st_e    row_st_d [N];
  logic [2:0] col_q [N];
  logic [2:0] col_d [N];

  logic [1:0] full_q, full_d;
  logic       cap_ptr_q, cap_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       ovf_q, ovf_d;
  out_st_e    ost_q, ost_d;
  logic [2:0] r_q, r_d;

  logic [N-1:0] arm, wr, fin, done_n;
  logic         tile_done, rd_free, cap_busy;

  // Per-row capture events; a bank freed on this edge counts as free.
  always_comb begin
    arm = '0;
    wr = '0;
    fin = '0;
    done_n = '0;
    rd_free = (ost_q == O_SEND) && out_ready
              && (r_q == 3'd7);
    cap_busy = full_q[cap_ptr_q]
               && !(rd_free && (rd_ptr_q == cap_ptr_q));
    for (int i = 0; i < N; i++) begin
      arm[i] = enable && clear_in[i];
      wr[i] = enable && !clear_in[i]
              && (row_st_q[i] == R_CAP);
      fin[i] = wr[i] && (col_q[i] == 3'd7);
      done_n[i] = fin[i]
                  || ((row_st_q[i] == R_DONE) && !arm[i]);
    end
    tile_done = &done_n;
  end

  // Row counters, bank flags, pointers and sticky overflow.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_st_d[i] = row_st_q[i];
      col_d[i] = col_q[i];
      if (tile_done) begin
        row_st_d[i] = R_IDLE;
        col_d[i] = 3'd0;
      end else if (arm[i]) begin
        row_st_d[i] = cap_busy ? R_IDLE : R_CAP;
        col_d[i] = 3'd0;
      end else if (wr[i]) begin
        row_st_d[i] = fin[i] ? R_DONE : R_CAP;
        col_d[i] = col_q[i] + 3'd1;
      end
    end
    full_d = full_q;
    if (rd_free) full_d[rd_ptr_q] = 1'b0;
    if (tile_done) full_d[cap_ptr_q] = 1'b1;
    cap_ptr_d = cap_ptr_q ^ tile_done;
    rd_ptr_d = rd_ptr_q ^ rd_free;
    ovf_d = ovf_q | ((|arm) & cap_busy);
  end

  // Output FSM: wait for a full read bank, then send its 8 rows.
  always_comb begin
    ost_d = ost_q;
    r_d = r_q;
    unique case (ost_q)
      O_IDLE: begin
        if (full_q[rd_ptr_q]) begin
          ost_d = O_SEND;
          r_d = 3'd0;
        end
      end
      O_SEND: begin
        if (out_ready) begin
          r_d = r_q + 3'd1;
          if (r_q == 3'd7) ost_d = O_IDLE;
        end
      end
      default: ost_d = O_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        row_st_q[i] <= R_IDLE;
        col_q[i] <= 3'd0;
      end
      full_q <= 2'b00;
      cap_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ovf_q <= 1'b0;
      ost_q <= O_IDLE;
      r_q <= 3'd0;
    end else begin
      for (int i = 0; i < N; i++) begin
        row_st_q[i] <= row_st_d[i];
        col_q[i] <= col_d[i];
      end
      full_q <= full_d;
      cap_ptr_q <= cap_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q <= ovf_d;
      ost_q <= ost_d;
      r_q <= r_d;
    end
  end

  // Tile storage: one word per capturing row per edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && wr[i])
        mem_q[cap_ptr_q][i][col_q[i]] <= z_in[i*DW +: DW];
    end
  end

  // Present the read-bank row; zero when idle.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++)
        out_data[k*DW +: DW] = mem_q[rd_ptr_q][r_q][k];
    end
  end

  assign out_valid = (ost_q == O_SEND);
  assign out_row = r_q;
  assign out_last = out_valid && (r_q == 3'd7);
  assign overflow = ovf_q;

`ifdef Z_DRAIN_BIN_CAPTURE_EN
  logic [N-1:0] bin_q [2][N];

  // b bits stored alongside each captured word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && wr[i])
        bin_q[cap_ptr_q][i][col_q[i]] <= b_in[i];
    end
  end

  assign out_bin = out_valid ? bin_q[rd_ptr_q][r_q] : '0;
`else
  logic unused_b;
  assign unused_b = ^b_in;
  assign out_bin = '0;
`endif

endmodule

// File: tb/tb_z_drain.sv
// tb_z_drain: directed scenarios for z_drain.
// Expected words are tag*1000 + 100*row + col.
module tb_z_drain;
  localparam int DW = 32;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            reset, enable, out_ready;
  logic [N*DW-1:0] z_in;
  logic [N-1:0]    clear_in, b_in;
  logic            out_valid, out_last, overflow;
  logic [N*DW-1:0] out_data;
  logic [2:0]      out_row;
  logic [N-1:0]    out_bin;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] got_data [8][8];
  logic [2:0]    got_row [8];
  logic          got_last [8];
  logic [N-1:0]  got_bin [8];
  int            got_n;
  bit            got_to;

  z_drain #(.DW(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .z_in(z_in), .clear_in(clear_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .out_bin(out_bin),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  // Drive ntiles skewed tiles, 16 active cycles apart.
  task automatic feed(input int ntiles, input int tag,
                      input int stall_at, input int stall_len,
                      input int rc_row, input int rc_at,
                      input int b_row, input int b_col);
    int p, last, s, rs, rel;
    last = 16*(ntiles-1) + 15 + (rc_at > 0 ? rc_at : 0);
    p = 0;
    for (int c = 0; p <= last; c++) begin
      @(negedge clk);
      clear_in = '0;
      b_in = '0;
      z_in = '0;
      if (c >= stall_at && c < stall_at + stall_len) begin
        enable = 1'b0;
        for (int i = 0; i < N; i++)
          z_in[i*DW +: DW] = 32'hDEAD0000 + c;
      end else begin
        enable = 1'b1;
        for (int t = 0; t < ntiles; t++) begin
          for (int i = 0; i < N; i++) begin
            s = 16*t + i;
            rs = s + ((i == rc_row) ? rc_at : 0);
            rel = p - rs;
            if (rel == 0) clear_in[i] = 1'b1;
            else if (rel >= 1 && rel <= 8) begin
              z_in[i*DW +: DW] = (tag+t)*1000 + 100*i + rel - 1;
              if (i == b_row && rel - 1 == b_col) b_in[i] = 1'b1;
            end
            if (i == rc_row && rc_at > 0) begin
              if (p == s) clear_in[i] = 1'b1;
              else if (p > s && p < rs) z_in[i*DW +: DW] = 9999;
            end
          end
        end
        p++;
      end
    end
    @(negedge clk);
    clear_in = '0;
    z_in = '0;
    b_in = '0;
    enable = 1'b1;
  endtask

  // Accept one full tile, recording each presented row.
  task automatic collect();
    got_n = 0;
    got_to = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 200 && got_n < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        for (int k = 0; k < 8; k++)
          got_data[got_n][k] = out_data[k*DW +: DW];
        got_row[got_n] = out_row;
        got_last[got_n] = out_last;
        got_bin[got_n] = out_bin;
        got_n++;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'b0;
      end
    end
    if (got_n < 8) got_to = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b0;
    z_in = '0;
    clear_in = '0;
    b_in = '0;
    idle(3);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid v=%b l=%b exp 0", out_valid, out_last);
    end
    total++;
    if (out_row !== 3'd0 || out_data !== '0 || out_bin !== '0) begin
      bad++;
      $display("FAIL reset_data row=%0d bin=%h exp 0", out_row, out_bin);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b exp 0", overflow);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    idle(10);
    feed(1, 0, -1, 0, -1, 0, -1, -1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat0 valid=%b exp 0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_lat1 valid=%b exp 1", out_valid);
    end
    collect();
    total++;
    if (got_to) begin
      bad++;
      $display("FAIL single_timeout rows=%0d exp 8", got_n);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (got_row[r] !== 3'(r) || got_last[r] !== (r == 7)) begin
        bad++;
        $display("FAIL single_row idx=%0d row=%0d last=%b", r, got_row[r], got_last[r]);
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (got_data[r][k] !== DW'(100*r + k)) begin
          bad++;
          $display("FAIL single_word r=%0d k=%0d got=%0d exp=%0d", r, k, got_data[r][k], 100*r + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] exp0;
    bit seen;
    feed(1, 5, -1, 0, -1, 0, -1, -1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_wait valid never rose");
    end
    for (int k = 0; k < 8; k++) exp0[k*DW +: DW] = DW'(5000 + k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_row !== 3'd0 || out_data !== exp0) begin
        bad++;
        $display("FAIL bp_hold c=%0d v=%b row=%0d w0=%0d exp row0", c, out_valid, out_row, out_data[DW-1:0]);
      end
    end
    collect();
    total++;
    if (got_to) begin
      bad++;
      $display("FAIL bp_timeout rows=%0d exp 8", got_n);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (got_row[r] !== 3'(r) || got_data[r][k] !== DW'(5000 + 100*r + k)) begin
          bad++;
          $display("FAIL bp_word r=%0d k=%0d got=%0d exp=%0d", r, k, got_data[r][k], 5000 + 100*r + k);
        end
      end
    end
  endtask

  task automatic test_enable_stall();
    feed(1, 4, 6, 3, -1, 0, -1, -1);
    collect();
    total++;
    if (got_to) begin
      bad++;
      $display("FAIL stall_timeout rows=%0d exp 8", got_n);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (got_data[r][k] !== DW'(4000 + 100*r + k)) begin
          bad++;
          $display("FAIL stall_word r=%0d k=%0d got=%0d exp=%0d", r, k, got_data[r][k], 4000 + 100*r + k);
        end
      end
    end
  endtask

  task automatic test_reclear();
    feed(1, 6, -1, 0, 2, 5, -1, -1);
    collect();
    total++;
    if (got_to) begin
      bad++;
      $display("FAIL reclear_timeout rows=%0d exp 8", got_n);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (got_data[r][k] !== DW'(6000 + 100*r + k)) begin
          bad++;
          $display("FAIL reclear_word r=%0d k=%0d got=%0d exp=%0d", r, k, got_data[r][k], 6000 + 100*r + k);
        end
      end
    end
  endtask

  task automatic test_bin();
    logic [N-1:0] exp3;
`ifdef Z_DRAIN_BIN_CAPTURE_EN
    exp3 = 8'b0010_0000;
`else
    exp3 = 8'b0000_0000;
`endif
    feed(1, 7, -1, 0, -1, 0, 3, 5);
    collect();
    total++;
    if (got_to) begin
      bad++;
      $display("FAIL bin_timeout rows=%0d exp 8", got_n);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (got_bin[r] !== ((r == 3) ? exp3 : 8'h00)) begin
        bad++;
        $display("FAIL bin_row r=%0d got=%b exp=%b", r, got_bin[r], (r == 3) ? exp3 : 8'h00);
      end
    end
  endtask

  task automatic test_overflow();
    bit seen;
    out_ready = 1'b0;
    feed(3, 1, -1, 0, -1, 0, -1, -1);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag got=%b exp 1", overflow);
    end
    for (int t = 0; t < 2; t++) begin
      collect();
      total++;
      if (got_to) begin
        bad++;
        $display("FAIL ovf_timeout tile=%0d rows=%0d", t, got_n);
      end
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < 8; k++) begin
          total++;
          if (got_data[r][k] !== DW'((1+t)*1000 + 100*r + k)) begin
            bad++;
            $display("FAIL ovf_word t=%0d r=%0d k=%0d got=%0d exp=%0d", t, r, k, got_data[r][k], (1+t)*1000 + 100*r + k);
          end
        end
      end
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL ovf_drop third tile valid=1 exp 0");
    end
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    feed(1, 8, -1, 0, -1, 0, -1, -1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    total++;
    if (!seen || overflow !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre valid=%b ovf=%b exp 1 1", out_valid, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL rst_mid valid=%b ovf=%b exp 0 0", out_valid, overflow);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rst_after valid rose after reset exp 0");
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_enable_stall();
    test_reclear();
    test_bin();
    test_overflow();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
